mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: maximum consecutive m0 grants while m1 waits.
REQ-002 Parameter LOCK_MAX, default 8: maximum consecutive locked m1 grants while m0 waits.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 m0_req/m1_req  input  1  master requests one bus beat; level-sensitive.
REQ-006 m0_wr/m1_wr  input  1  beat is a write when 1 and a read when 0.
REQ-007 m0_addr/m1_addr  input  32  byte address of the beat.
REQ-008 m0_wdata/m1_wdata  input  32  write data.
REQ-009 m1_lock  input  1  m1 requests back-to-back beats without m0 interleaving.
REQ-010 m0_gnt/m1_gnt  output  1  registered; high for exactly the cycle in which that master's beat executes.
REQ-011 m0_done/m1_done  output  1  one-cycle pulse in the cycle after the grant cycle.
REQ-012 m0_err/m1_err  output  1  pulses with done when the beat address was misaligned.
REQ-013 m0_rdata/m1_rdata  output  32  registered read data; valid when done pulses; holds value until the next read completes.
REQ-014 mem_rd, mem_wr  output  1  strobes to the single-port data memory and peripheral bus.
REQ-015 mem_addr, mem_wdata  output  32  address and write data to memory.
REQ-016 mem_rdata  input  32  combinational read data from memory, which writes on posedge clk.

Function
REQ-017 The state machine SHALL have states IDLE, G0 and G1; gnt outputs decode the state (G0 gives m0_gnt=1, G1 gives m1_gnt=1).
REQ-018 Next state is computed every cycle from current req/lock/counters; any state may go to any state.
REQ-019 A high req in a master's own grant cycle requests a further beat; the master presents the next addr/wdata after that edge.
REQ-020 Priority: m0 wins over m1, except for the starvation and lock rules below.
REQ-021 Starvation: starve_cnt increments on each G0 cycle while m1_req=1 and clears in G1 or when m1_req=0; when starve_cnt==STARVE_MAX and both requests are high, next state is G1.
REQ-022 Lock: in G1 with m1_req=1 and m1_lock=1, next state is G1 regardless of m0_req, while lock_cnt<LOCK_MAX-1.
REQ-023 lock_cnt counts consecutive G1 beats; at LOCK_MAX beats with m0_req=1, next state is G0; it clears on leaving G1.
REQ-024 No request means next state IDLE.
REQ-025 In G0/G1, mem_addr, mem_wdata and mem_wr/mem_rd are driven from the granted master's live inputs; in IDLE all mem_* outputs are 0.
REQ-026 Misaligned beat (addr[1:0]!=0): mem_rd=mem_wr=0 for that grant cycle; done and err pulse next cycle; rdata unchanged.
REQ-027 For an aligned read, mem_rdata is captured into the granted master's rdata at the end of the grant cycle, so latency is req high at cycle N, gnt at N+1, done+rdata at N+2 (from IDLE).
REQ-028 An aligned write completes on the grant-cycle edge; done pulses next cycle with err=0.
REQ-029 m0_gnt and m1_gnt are never both 1; mem_rd and mem_wr are never both 1.
REQ-030 Throughput: one beat per cycle for continuous requests.

Reset
REQ-031 While reset=0: state=IDLE; all gnt/done/err=0; rdata=0; starve_cnt=lock_cnt=0; mem_* = 0.
REQ-032 Reset asserted mid-beat abandons the beat: no done pulse is issued after release.
REQ-033 Arbitration resumes on the first posedge clk after reset deasserts.

Structure
REQ-034 Shared package mem_arb_pkg holds the state enum (IDLE/G0/G1) and the default STARVE_MAX/LOCK_MAX constants.
REQ-035 A sub-module mem_arb_port (rdata capture plus done/err pulse generation) SHALL be instantiated once per master.
REQ-036 Counters SHALL be sized to hold max(STARVE_MAX, LOCK_MAX).

Verification
REQ-037 m0 read of addr 0x10 from IDLE, with memory returning 0xDEADBEEF: m0_gnt at N+1, m0_done at N+2 with m0_rdata=0xDEADBEEF.
REQ-038 m0_req and m1_req held high continuously: grant pattern is G0 x4, G1, G0 x4, G1, ...
REQ-039 m1 locked burst of 10 beats while m0_req is high: G1 x8, G0, then the remaining G1 beats.
REQ-040 m1 write to addr 0x13: mem_wr=0 in the grant cycle; m1_done=m1_err=1 next cycle.
REQ-041 Reset pulled low during a G0 read: all outputs 0 immediately; no m0_done after release.
REQ-042 Random concurrent traffic: assert grant and strobe mutual exclusion every cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-master memory arbiter.
// Holds the grant-state encoding and counter sizing helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  localparam int STARVE_MAX_DEF = 4;
  localparam int LOCK_MAX_DEF   = 8;

  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mem_arb_port.sv
// Per-master completion logic: done/err pulses and read-data capture.
// One instance sits behind each arbiter grant.
module mem_arb_port (
  input  logic        clk,
  input  logic        reset,
  input  logic        gnt,
  input  logic        wr,
  input  logic        misal,
  input  logic [31:0] mem_rdata,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done  <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      done <= gnt;
      err  <= gnt && misal;
      if (gnt && !wr && !misal)
        rdata <= mem_rdata;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master single-port memory arbiter with starvation guard
// and bounded m1 lock bursts; one beat per cycle.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int LOCK_MAX   = LOCK_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_done,
  output logic        m1_done,
  output logic        m0_err,
  output logic        m1_err,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = cnt_w(STARVE_MAX, LOCK_MAX);
  localparam logic [CW-1:0] S_MAX = CW'(STARVE_MAX);
  localparam logic [CW-1:0] L_MAX = CW'(LOCK_MAX);
  localparam logic [CW-1:0] L_LIM = CW'(LOCK_MAX - 1);

  arb_state_e    state;
  arb_state_e    state_nxt;
  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] starve_nxt;
  logic [CW-1:0] lock_cnt;
  logic [CW-1:0] lock_nxt;
  beat_t         b0;
  beat_t         b1;
  beat_t         sel;
  logic          in_g0;
  logic          in_g1;
  logic          misal;
  logic          starved;
  logic          locked;
  logic          pick_g0;
  logic          pick_g1;

  assign in_g0 = (state == G0);
  assign in_g1 = (state == G1);
  assign b0    = {m0_wr, m0_addr, m0_wdata};
  assign b1    = {m1_wr, m1_addr, m1_wdata};

  // m1 wait count includes the current G0 beat
  always_comb begin
    starve_nxt = starve_cnt;
    if (in_g1 || !m1_req)
      starve_nxt = '0;
    else if (in_g0 && starve_cnt != S_MAX)
      starve_nxt = starve_cnt + 1'b1;
  end

  always_comb begin
    lock_nxt = '0;
    if (in_g1)
      lock_nxt = (lock_cnt != L_MAX) ? lock_cnt + 1'b1 : lock_cnt;
  end

  assign starved = m0_req && m1_req && (starve_nxt >= S_MAX);
  assign locked  = in_g1 && m1_req && m1_lock && (lock_cnt < L_LIM);
  assign pick_g1 = locked || starved || (!m0_req && m1_req);
  assign pick_g0 = m0_req && !locked && !starved;

  always_comb begin
    state_nxt = IDLE;
    unique case (1'b1)
      pick_g1: state_nxt = G1;
      pick_g0: state_nxt = G0;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lock_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      lock_cnt   <= lock_nxt;
    end
  end

  always_comb begin
    sel = '0;
    unique case (state)
      G0:      sel = b0;
      G1:      sel = b1;
      default: sel = '0;
    endcase
  end

  // misaligned beats reach no memory strobe
  assign misal     = |sel.addr[1:0];
  assign mem_addr  = sel.addr;
  assign mem_wdata = sel.wdata;
  assign mem_wr    = (in_g0 || in_g1) && sel.wr && !misal;
  assign mem_rd    = (in_g0 || in_g1) && !sel.wr && !misal;
  assign m0_gnt    = in_g0;
  assign m1_gnt    = in_g1;

  mem_arb_port u_port0 (
    .clk       (clk),
    .reset     (reset),
    .gnt       (in_g0),
    .wr        (m0_wr),
    .misal     (misal),
    .mem_rdata (mem_rdata),
    .done      (m0_done),
    .err       (m0_err),
    .rdata     (m0_rdata)
  );

  mem_arb_port u_port1 (
    .clk       (clk),
    .reset     (reset),
    .gnt       (in_g1),
    .wr        (m1_wr),
    .misal     (misal),
    .mem_rdata (mem_rdata),
    .done      (m1_done),
    .err       (m1_err),
    .rdata     (m1_rdata)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table with done scoreboard,
// plus starvation, lock-burst, reset and random sequences.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_wr, m1_req, m1_wr, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    bit          m;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          eerr;
    logic [31:0] erdata;
  } vec_t;

  typedef struct {
    bit          m;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  vec_t        tbl [11];
  exp_t        sbq [$];
  logic [31:0] mem [64];
  int          n_vec;
  int          n_bad;
  bit          sb_on;

  mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_wr     (m0_wr),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m1_req    (m1_req),
    .m1_wr     (m1_wr),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_lock   (m1_lock),
    .m0_gnt    (m0_gnt),
    .m1_gnt    (m1_gnt),
    .m0_done   (m0_done),
    .m1_done   (m1_done),
    .m0_err    (m0_err),
    .m1_err    (m1_err),
    .m0_rdata  (m0_rdata),
    .m1_rdata  (m1_rdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++)
        mem[i] <= 32'h100 + 32'(i);
      mem[4] <= 32'hDEADBEEF;
    end else if (mem_wr) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clr();
    m0_req = 0; m0_wr = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_wr = 0; m1_addr = 0; m1_wdata = 0;
    m1_lock = 0;
  endtask

  function automatic logic [31:0] gcode();
    return 32'({m1_gnt, m0_gnt});
  endfunction

  always @(negedge clk) begin
    if (sb_on && (m0_done || m1_done)) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_done", 32'({m1_done, m0_done}), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_done_who", 32'({m1_done, m0_done}), e.m ? 32'd2 : 32'd1);
        chk("sb_err", 32'(e.m ? m1_err : m0_err), 32'(e.err));
        chk("sb_rdata", e.m ? m1_rdata : m0_rdata, e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sp [11];
    int lp [13];
    int n1;
    bit went;
    bit anyreq;
    vec_t v;
    bit al;

    tbl[0]  = '{1'b0, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[1]  = '{1'b1, 1'b1, 32'h20, 32'h11112222, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 32'h20, 32'h0,        1'b0, 32'h11112222};
    tbl[3]  = '{1'b0, 1'b1, 32'h24, 32'hCAFEF00D, 1'b0, 32'hDEADBEEF};
    tbl[4]  = '{1'b0, 1'b0, 32'h24, 32'h0,        1'b0, 32'hCAFEF00D};
    tbl[5]  = '{1'b1, 1'b1, 32'h13, 32'h55555555, 1'b1, 32'h11112222};
    tbl[6]  = '{1'b0, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[7]  = '{1'b1, 1'b0, 32'h22, 32'h0,        1'b1, 32'h11112222};
    tbl[8]  = '{1'b0, 1'b0, 32'h13, 32'h0,        1'b1, 32'hDEADBEEF};
    tbl[9]  = '{1'b0, 1'b1, 32'h10, 32'h12345678, 1'b0, 32'hDEADBEEF};
    tbl[10] = '{1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 32'h12345678};
    sp = '{0, 1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
    lp = '{0, 2, 2, 2, 2, 2, 2, 2, 2, 1, 2, 2, 0};

    n_vec = 0;
    n_bad = 0;
    sb_on = 0;
    reset = 0;
    clr();

    #12;
    chk("rst_gnt", gcode(), 32'd0);
    chk("rst_done", 32'({m1_done, m0_done, m1_err, m0_err}), 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_strobe", 32'({mem_rd, mem_wr}), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    reset = 1;
    sb_on = 1;

    for (int i = 0; i < 11; i++) begin
      v = tbl[i];
      al = (v.addr[1:0] == 2'b00);
      @(posedge clk); #1;
      if (v.m) begin
        m1_req = 1; m1_wr = v.wr; m1_addr = v.addr; m1_wdata = v.wdata;
      end else begin
        m0_req = 1; m0_wr = v.wr; m0_addr = v.addr; m0_wdata = v.wdata;
      end
      sbq.push_back('{v.m, v.eerr, v.erdata});
      @(posedge clk); #1;
      m0_req = 0;
      m1_req = 0;
      @(negedge clk);
      chk("v_gnt", gcode(), v.m ? 32'd2 : 32'd1);
      chk("v_mem_wr", 32'(mem_wr), 32'(v.wr & al));
      chk("v_mem_rd", 32'(mem_rd), 32'(!v.wr & al));
      chk("v_mem_addr", mem_addr, v.addr);
      chk("v_mem_wdata", mem_wdata, v.wdata);
      @(posedge clk); #1;
      clr();
      @(negedge clk);
    end
    @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    sb_on = 0;

    @(posedge clk); #1;
    m0_addr = 32'h10;
    m1_addr = 32'h20;
    m0_req = 1;
    m1_req = 1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk($sformatf("starve_%0d", i), gcode(), 32'(sp[i]));
      @(posedge clk); #1;
    end
    clr();
    repeat (3) @(posedge clk);
    #1;

    n1 = 0;
    went = 0;
    m1_addr = 32'h20;
    m1_req = 1;
    m1_lock = 1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      chk($sformatf("lock_%0d", i), gcode(), 32'(lp[i]));
      @(posedge clk); #1;
      if (m1_gnt) begin
        n1++;
        if (n1 == 10) m1_req = 0;
        if (!went) begin
          m0_req = 1;
          m0_addr = 32'h10;
        end
      end
      if (m0_gnt) begin
        m0_req = 0;
        went = 1;
      end
    end
    clr();
    repeat (3) @(posedge clk);
    #1;

    sb_on = 1;
    m0_addr = 32'h10;
    m0_req = 1;
    @(posedge clk); #1;
    m0_req = 0;
    @(negedge clk);
    chk("rst_mid_gnt", gcode(), 32'd1);
    chk("rst_mid_rd", 32'(mem_rd), 32'd1);
    #2;
    reset = 0;
    #1;
    chk("rst_async_gnt", gcode(), 32'd0);
    chk("rst_async_strobe", 32'({mem_rd, mem_wr}), 32'd0);
    chk("rst_async_addr", mem_addr, 32'd0);
    chk("rst_async_rdata", m0_rdata | m1_rdata, 32'd0);
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_done", 32'({m1_done, m0_done}), 32'd0);
    end
    clr();
    sb_on = 0;

    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      anyreq = m0_req | m1_req;
      m0_req   = 1'($urandom_range(0, 1));
      m1_req   = 1'($urandom_range(0, 1));
      m1_lock  = 1'($urandom_range(0, 1));
      m0_wr    = 1'($urandom_range(0, 1));
      m1_wr    = 1'($urandom_range(0, 1));
      m0_addr  = $urandom & 32'hFF;
      m1_addr  = $urandom & 32'hFF;
      m0_wdata = $urandom;
      m1_wdata = $urandom;
      @(negedge clk);
      chk("rnd_gnt_mutex", 32'(m0_gnt & m1_gnt), 32'd0);
      chk("rnd_strobe_mutex", 32'(mem_rd & mem_wr), 32'd0);
      chk("rnd_served", 32'(m0_gnt | m1_gnt), 32'(anyreq));
    end
    clr();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
